// File: rtl/led_blink_multi.sv
// N-channel LED blinker / clock divider. Each channel has its own period, duty threshold and mode;
// new settings wait in a shadow register and are adopted at the channel's next wrap.
module led_blink_multi #(
    parameter int                  CHANNELS   = 5,
    parameter int                  CNT_W      = 24,
    parameter logic [CNT_W-1:0]    DEF_PERIOD = CNT_W'(11_999_999),
    parameter logic [1:0]          DEF_MODE   = 2'b01,
    parameter logic [CHANNELS-1:0] RST_LED    = CHANNELS'(5'b10000)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ena_i,
    input  logic                      sync_i,
    input  logic                      load_i,
    input  logic [CHANNELS*CNT_W-1:0] period_i,
    input  logic [CHANNELS*CNT_W-1:0] duty_i,
    input  logic [CHANNELS*2-1:0]     mode_i,
    output logic [CHANNELS-1:0]       led_o,
    output logic [CHANNELS-1:0]       tick_o
);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_PULSE  = 2'b10;
    localparam logic [1:0] MODE_PWM    = 2'b11;

    // Default duty is half the period, rounded up; one extra bit keeps P+1 from overflowing.
    localparam logic [CNT_W:0]   DEF_PERIOD_WIDE = {1'b0, DEF_PERIOD};
    localparam logic [CNT_W:0]   DEF_DUTY_WIDE   = (DEF_PERIOD_WIDE + (CNT_W+1)'(1)) >> 1;
    localparam logic [CNT_W-1:0] DEF_DUTY        = DEF_DUTY_WIDE[CNT_W-1:0];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [CNT_W-1:0] cnt, period, duty, shadow_period, shadow_duty;
        logic [1:0]       mode, shadow_mode;
        logic             pending, led, tick;

        logic [CNT_W-1:0] in_period, in_duty, cnt_next, next_period, next_duty, eff_duty;
        logic [1:0]       in_mode, next_mode, eff_mode;
        logic             wrap, apply, led_next;

        assign in_period = period_i[k*CNT_W +: CNT_W];
        assign in_duty   = duty_i[k*CNT_W +: CNT_W];
        assign in_mode   = mode_i[k*2 +: 2];

        // A load coinciding with the adoption point bypasses the shadow so it takes effect at once.
        always_comb begin
            wrap        = (cnt == period);
            cnt_next    = wrap ? '0 : cnt + CNT_W'(1);
            apply       = wrap && (pending || load_i);
            next_period = load_i ? in_period : shadow_period;
            next_duty   = load_i ? in_duty   : shadow_duty;
            next_mode   = load_i ? in_mode   : shadow_mode;
            eff_mode    = apply ? next_mode : mode;
            eff_duty    = apply ? next_duty : duty;
            led_next    = 1'b0;
            case (eff_mode)
                MODE_OFF:    led_next = 1'b0;
                MODE_TOGGLE: led_next = wrap ? ~led : led;
                MODE_PULSE:  led_next = wrap;
                MODE_PWM:    led_next = (cnt_next < eff_duty);
                default:     led_next = 1'b0;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt           <= '0;
                led           <= RST_LED[k];
                tick          <= 1'b0;
                period        <= DEF_PERIOD;
                duty          <= DEF_DUTY;
                mode          <= DEF_MODE;
                shadow_period <= DEF_PERIOD;
                shadow_duty   <= DEF_DUTY;
                shadow_mode   <= DEF_MODE;
                pending       <= 1'b0;
            end else if (sync_i) begin
                cnt     <= '0;
                tick    <= 1'b0;
                period  <= next_period;
                duty    <= next_duty;
                mode    <= next_mode;
                pending <= 1'b0;
                led     <= RST_LED[k] & (next_mode != MODE_OFF);
                if (load_i) begin
                    shadow_period <= in_period;
                    shadow_duty   <= in_duty;
                    shadow_mode   <= in_mode;
                end
            end else if (!ena_i) begin
                tick <= 1'b0;
                if (load_i) begin
                    shadow_period <= in_period;
                    shadow_duty   <= in_duty;
                    shadow_mode   <= in_mode;
                    pending       <= 1'b1;
                end
            end else begin
                cnt  <= cnt_next;
                tick <= wrap;
                led  <= led_next;
                if (load_i) begin
                    shadow_period <= in_period;
                    shadow_duty   <= in_duty;
                    shadow_mode   <= in_mode;
                end
                if (apply) begin
                    period  <= next_period;
                    duty    <= next_duty;
                    mode    <= next_mode;
                    pending <= 1'b0;
                end else if (load_i) begin
                    pending <= 1'b1;
                end
            end
        end

        assign led_o[k]  = led;
        assign tick_o[k] = tick;
    end

endmodule
